// File: rtl/asap_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asap_sequencer_pkg
// Brief    : Control bit indices, opcodes and sequencer state encodings
// Revision : 1.0
// ============================================================================
package asap_sequencer_pkg;

    localparam int CONTROL_SIGNALS = 17;
    localparam int CTRL_W          = CONTROL_SIGNALS;

    localparam int AI  = 0;
    localparam int AO  = 1;
    localparam int BI  = 2;
    localparam int BO  = 3;
    localparam int MAI = 4;
    localparam int OUI = 5;
    localparam int II  = 6;
    localparam int OI  = 7;
    localparam int OO  = 8;
    localparam int ALO = 9;
    localparam int ALS = 10;
    localparam int PCI = 11;
    localparam int PCO = 12;
    localparam int PCS = 13;
    localparam int MI  = 14;
    localparam int MO  = 15;
    localparam int HLT = 16;

    localparam int OP_NOP = 0;
    localparam int OP_LDA = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_STA = 4;
    localparam int OP_LDI = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JC  = 7;
    localparam int OP_JZ  = 8;
    localparam int OP_OUT = 14;
    localparam int OP_HLT = 15;

    localparam logic [1:0] S_PAUSE = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        return {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/asap_microcode.sv
`default_nettype none
// ============================================================================
// Module   : asap_microcode
// Brief    : Combinational microstep decode: (opcode, T-state, flags) -> ctrl
// Revision : 1.0
// ============================================================================
module asap_microcode
    import asap_sequencer_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int T_W  = 3
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [T_W-1:0]    t_state,
    input  logic              zf,
    input  logic              cf,
    output logic [CTRL_W-1:0] ctrl,
    output logic              last_step
);

    int   w_op;
    int   w_t;
    int   w_base;
    int   w_len;
    int   w_e;
    logic w_operand;

    always_comb begin
        ctrl      = '0;
        w_op      = int'(opcode);
        w_t       = int'(t_state);
        w_operand = (w_op >= OP_LDA) && (w_op <= OP_JZ);
        w_base    = w_operand ? 4 : 2;

        // Execute length; an untaken branch has no execute step at all
        case (w_op)
            OP_LDA, OP_STA:                 w_len = 2;
            OP_ADD, OP_SUB:                 w_len = 3;
            OP_LDI, OP_JMP, OP_OUT, OP_HLT: w_len = 1;
            OP_JC:                          w_len = cf ? 1 : 0;
            OP_JZ:                          w_len = zf ? 1 : 0;
            default:                        w_len = 0;
        endcase
        w_e = w_t - w_base;

        if (w_t == 0) begin
            ctrl = cbit(PCO) | cbit(MAI);
        end else if (w_t == 1) begin
            ctrl = cbit(MO) | cbit(II) | cbit(PCS);
        end else if (w_operand && (w_t == 2)) begin
            ctrl = cbit(PCO) | cbit(MAI);
        end else if (w_operand && (w_t == 3)) begin
            ctrl = cbit(MO) | cbit(OI) | cbit(PCS);
        end else if (w_e < w_len) begin
            case (w_op)
                OP_LDA: ctrl = (w_e == 0) ? (cbit(OO) | cbit(MAI)) : (cbit(MO) | cbit(AI));
                OP_ADD, OP_SUB: begin
                    case (w_e)
                        0:       ctrl = cbit(OO) | cbit(MAI);
                        1:       ctrl = cbit(MO) | cbit(BI);
                        default: ctrl = cbit(ALO) | cbit(AI) | ((w_op == OP_SUB) ? cbit(ALS) : '0);
                    endcase
                end
                OP_STA:                ctrl = (w_e == 0) ? (cbit(OO) | cbit(MAI)) : (cbit(AO) | cbit(MI));
                OP_LDI:                ctrl = cbit(OO) | cbit(AI);
                OP_JMP, OP_JC, OP_JZ:  ctrl = cbit(OO) | cbit(PCI);
                OP_OUT:                ctrl = cbit(AO) | cbit(OUI);
                OP_HLT:                ctrl = cbit(HLT);
                default:               ctrl = '0;
            endcase
        end

        // Zero-length execute ends on the last fetch step (T1 or T3)
        last_step = (w_t == (w_base + w_len - 1));
    end

endmodule
`default_nettype wire

// File: rtl/asap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : asap_sequencer
// Brief    : SAP-style control sequencer with run/step/halt handling
// Revision : 1.0
// ============================================================================
module asap_sequencer
    import asap_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int MAX_T  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     step_req,
    input  logic                     zf,
    input  logic                     cf,
    input  logic [DATA_W-1:0]        ireg,
    output logic [CTRL_W-1:0]        ctrl,
    output logic [$clog2(MAX_T)-1:0] t_state,
    output logic                     halted,
    output logic                     instr_done
);

    localparam int             T_W     = $clog2(MAX_T);
    localparam logic [T_W-1:0] C_T_TOP = T_W'(MAX_T - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [T_W-1:0]    r_t;
    logic [T_W-1:0]    w_t_nxt;
    logic              r_stepping;
    logic              w_stepping_nxt;
    logic [CTRL_W-1:0] w_uctrl;
    logic              w_last;
    logic              w_unused_operand;

    // Low ireg bits hold the operand address, which this block never decodes
    assign w_unused_operand = ^ireg[DATA_W-OP_W-1:0];

    asap_microcode #(
        .OP_W (OP_W),
        .T_W  (T_W)
    ) u_microcode (
        .opcode    (ireg[DATA_W-1 -: OP_W]),
        .t_state   (r_t),
        .zf        (zf),
        .cf        (cf),
        .ctrl      (w_uctrl),
        .last_step (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_PAUSE;
            r_t        <= '0;
            r_stepping <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_t        <= w_t_nxt;
            r_stepping <= w_stepping_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_t_nxt        = r_t;
        w_stepping_nxt = r_stepping;
        ctrl           = '0;
        instr_done     = 1'b0;
        case (r_state)
            S_PAUSE: begin
                w_t_nxt = '0;
                if (run || step_req) begin
                    w_state_nxt    = S_RUN;
                    w_stepping_nxt = !run;
                end
            end
            S_RUN: begin
                ctrl       = w_uctrl;
                instr_done = w_last;
                if (w_last) begin
                    w_t_nxt = '0;
                    if (w_uctrl[HLT]) begin
                        w_state_nxt = S_HALT;
                    end else if (!run || r_stepping) begin
                        w_state_nxt = S_PAUSE;
                    end
                end else if (r_t == C_T_TOP) begin
                    w_t_nxt = '0;
                end else begin
                    w_t_nxt = r_t + T_W'(1);
                end
            end
            S_HALT: begin
                w_t_nxt = '0;
            end
            default: begin
                w_state_nxt = S_PAUSE;
                w_t_nxt     = '0;
            end
        endcase
    end

    assign t_state = r_t;
    assign halted  = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_asap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_asap_sequencer
// Brief    : Directed self-checking bench for asap_sequencer
// Revision : 1.0
// ============================================================================
module tb_asap_sequencer;
    import asap_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic              step_req;
    logic              zf;
    logic              cf;
    logic [7:0]        ireg;
    logic [CTRL_W-1:0] ctrl;
    logic [2:0]        t_state;
    logic              halted;
    logic              instr_done;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [CTRL_W-1:0] B1       = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] F0       = (B1 << PCO) | (B1 << MAI);
    localparam logic [CTRL_W-1:0] F1       = (B1 << MO) | (B1 << II) | (B1 << PCS);
    localparam logic [CTRL_W-1:0] O3       = (B1 << MO) | (B1 << OI) | (B1 << PCS);
    localparam logic [CTRL_W-1:0] X_OO_MAI = (B1 << OO) | (B1 << MAI);
    localparam logic [CTRL_W-1:0] X_MO_BI  = (B1 << MO) | (B1 << BI);
    localparam logic [CTRL_W-1:0] X_ALO_AI = (B1 << ALO) | (B1 << AI);
    localparam logic [CTRL_W-1:0] X_SUB    = (B1 << ALO) | (B1 << ALS) | (B1 << AI);
    localparam logic [CTRL_W-1:0] X_OO_AI  = (B1 << OO) | (B1 << AI);
    localparam logic [CTRL_W-1:0] X_OO_PCI = (B1 << OO) | (B1 << PCI);
    localparam logic [CTRL_W-1:0] X_AO_OUI = (B1 << AO) | (B1 << OUI);
    localparam logic [CTRL_W-1:0] X_HLT    = (B1 << HLT);

    asap_sequencer #(
        .DATA_W (8),
        .OP_W   (4),
        .MAX_T  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step_req   (step_req),
        .zf         (zf),
        .cf         (cf),
        .ireg       (ireg),
        .ctrl       (ctrl),
        .t_state    (t_state),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; run = 1'b0; step_req = 1'b0; zf = 1'b0; cf = 1'b0; ireg = 8'h00;
        #12;
        n_checks++; if (ctrl !== '0) begin n_errors++; $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
        n_checks++; if (t_state !== 3'd0) begin n_errors++; $display("FAIL reset_t: got %0d expected 0", t_state); end
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (instr_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", instr_done); end
        #1 rst_n = 1'b1;
        tick;
        n_checks++; if (ctrl !== '0) begin n_errors++; $display("FAIL reset_idle_ctrl: got %h expected 0", ctrl); end
    endtask

    task automatic test_ldi;
        logic [CTRL_W-1:0] exp [5] = '{F0, F1, F0, O3, X_OO_AI};
        ireg = 8'h52; run = 1'b1;
        tick;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (ctrl !== exp[i]) begin n_errors++; $display("FAIL ldi_ctrl T%0d: got %h expected %h", i, ctrl, exp[i]); end
            n_checks++; if (t_state !== 3'(i)) begin n_errors++; $display("FAIL ldi_t: got %0d expected %0d", t_state, i); end
            n_checks++; if (instr_done !== (i == 4)) begin n_errors++; $display("FAIL ldi_done T%0d: got %b expected %b", i, instr_done, (i == 4)); end
            if (i == 4) run = 1'b0;
            tick;
        end
        n_checks++; if (ctrl !== '0 || t_state !== 3'd0) begin n_errors++; $display("FAIL ldi_pause: got ctrl %h t %0d expected 0/0", ctrl, t_state); end
    endtask

    task automatic test_sub;
        logic [CTRL_W-1:0] exp [7] = '{F0, F1, F0, O3, X_OO_MAI, X_MO_BI, X_SUB};
        ireg = 8'h3A; run = 1'b1;
        tick;
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (ctrl !== exp[i]) begin n_errors++; $display("FAIL sub_ctrl T%0d: got %h expected %h", i, ctrl, exp[i]); end
            n_checks++; if (instr_done !== (i == 6)) begin n_errors++; $display("FAIL sub_done T%0d: got %b expected %b", i, instr_done, (i == 6)); end
            if (i == 2) run = 1'b0;
            tick;
        end
        n_checks++; if (t_state !== 3'd0 || ctrl !== '0) begin n_errors++; $display("FAIL sub_end: got t %0d ctrl %h expected 0/0", t_state, ctrl); end
    endtask

    task automatic test_branches;
        logic [CTRL_W-1:0] exp [4] = '{F0, F1, F0, O3};
        ireg = 8'h71; cf = 1'b0; run = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ctrl !== exp[i]) begin n_errors++; $display("FAIL jc0_ctrl T%0d: got %h expected %h", i, ctrl, exp[i]); end
            n_checks++; if (instr_done !== (i == 3)) begin n_errors++; $display("FAIL jc0_done T%0d: got %b expected %b", i, instr_done, (i == 3)); end
            tick;
        end
        n_checks++; if (t_state !== 3'd0 || ctrl !== F0) begin n_errors++; $display("FAIL jc0_next: got t %0d ctrl %h expected 0/%h", t_state, ctrl, F0); end
        cf = 1'b1;
        tick; tick; tick;
        n_checks++; if (instr_done !== 1'b0) begin n_errors++; $display("FAIL jc1_t3_done: got %b expected 0", instr_done); end
        tick;
        n_checks++; if (ctrl !== X_OO_PCI) begin n_errors++; $display("FAIL jc1_ctrl: got %h expected %h", ctrl, X_OO_PCI); end
        n_checks++; if (instr_done !== 1'b1) begin n_errors++; $display("FAIL jc1_done: got %b expected 1", instr_done); end
        run = 1'b0;
        tick;
        cf = 1'b0; zf = 1'b1; ireg = 8'h80; run = 1'b1;
        tick;
        tick; tick; tick; tick;
        n_checks++; if (ctrl !== X_OO_PCI || t_state !== 3'd4) begin n_errors++; $display("FAIL jz1: got ctrl %h t %0d expected %h/4", ctrl, t_state, X_OO_PCI); end
        run = 1'b0;
        tick;
        zf = 1'b0;
        n_checks++; if (ctrl !== '0) begin n_errors++; $display("FAIL jz_pause: got %h expected 0", ctrl); end
    endtask

    task automatic test_back_to_back;
        ireg = 8'h00; run = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (t_state !== 3'(i % 2) || instr_done !== (i % 2 == 1)) begin
                n_errors++; $display("FAIL nop_seq %0d: got t %0d done %b expected %0d/%b", i, t_state, instr_done, i % 2, (i % 2 == 1));
            end
            n_checks++; if (ctrl !== ((i % 2 == 1) ? F1 : F0)) begin n_errors++; $display("FAIL nop_ctrl %0d: got %h", i, ctrl); end
            tick;
        end
        ireg = 8'hE0;
        n_checks++; if (ctrl !== F0) begin n_errors++; $display("FAIL out_t0: got %h expected %h", ctrl, F0); end
        tick;
        n_checks++; if (ctrl !== F1 || instr_done !== 1'b0) begin n_errors++; $display("FAIL out_t1: got %h/%b expected %h/0", ctrl, instr_done, F1); end
        tick;
        n_checks++; if (ctrl !== X_AO_OUI || instr_done !== 1'b1) begin n_errors++; $display("FAIL out_t2: got %h/%b expected %h/1", ctrl, instr_done, X_AO_OUI); end
        run = 1'b0;
        tick;
        n_checks++; if (ctrl !== '0) begin n_errors++; $display("FAIL out_pause: got %h expected 0", ctrl); end
    endtask

    task automatic test_step;
        int active = 0;
        ireg = 8'h2C; run = 1'b0; step_req = 1'b1;
        tick;
        step_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (ctrl !== '0) active++;
            n_checks++; if (t_state !== 3'(i)) begin n_errors++; $display("FAIL step_t: got %0d expected %0d", t_state, i); end
            if (i == 6) begin
                n_checks++; if (ctrl !== X_ALO_AI || instr_done !== 1'b1) begin n_errors++; $display("FAIL step_t6: got %h/%b expected %h/1", ctrl, instr_done, X_ALO_AI); end
            end
            step_req = (i == 3);
            tick;
            step_req = 1'b0;
        end
        n_checks++; if (active != 7) begin n_errors++; $display("FAIL step_active: got %0d expected 7", active); end
        n_checks++; if (ctrl !== '0 || t_state !== 3'd0) begin n_errors++; $display("FAIL step_pause: got %h/%0d expected 0/0", ctrl, t_state); end
        tick;
        n_checks++; if (ctrl !== '0) begin n_errors++; $display("FAIL step_ignored: got %h expected 0", ctrl); end
    endtask

    task automatic test_reset_mid;
        ireg = 8'h20; run = 1'b1;
        tick;
        tick; tick; tick; tick; tick;
        n_checks++; if (t_state !== 3'd5 || ctrl !== X_MO_BI) begin n_errors++; $display("FAIL rmid_t5: got %0d/%h expected 5/%h", t_state, ctrl, X_MO_BI); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (ctrl !== '0 || t_state !== 3'd0 || instr_done !== 1'b0) begin
            n_errors++; $display("FAIL rmid_async: got ctrl %h t %0d done %b expected 0/0/0", ctrl, t_state, instr_done);
        end
        #1 rst_n = 1'b1;
        tick;
        n_checks++; if (t_state !== 3'd0 || ctrl !== F0) begin n_errors++; $display("FAIL rmid_restart: got %0d/%h expected 0/%h", t_state, ctrl, F0); end
        tick;
        n_checks++; if (t_state !== 3'd1 || ctrl !== F1) begin n_errors++; $display("FAIL rmid_t1: got %0d/%h expected 1/%h", t_state, ctrl, F1); end
        run = 1'b0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_halt;
        int bad = 0;
        ireg = 8'hF0; run = 1'b1;
        tick;
        n_checks++; if (ctrl !== F0) begin n_errors++; $display("FAIL hlt_t0: got %h expected %h", ctrl, F0); end
        tick;
        tick;
        n_checks++; if (ctrl !== X_HLT || instr_done !== 1'b1 || t_state !== 3'd2) begin
            n_errors++; $display("FAIL hlt_t2: got %h/%b/%0d expected %h/1/2", ctrl, instr_done, t_state, X_HLT);
        end
        tick;
        n_checks++; if (halted !== 1'b1 || ctrl !== '0 || instr_done !== 1'b0) begin
            n_errors++; $display("FAIL hlt_enter: got halted %b ctrl %h done %b expected 1/0/0", halted, ctrl, instr_done);
        end
        for (int i = 0; i < 20; i++) begin
            run = (i % 2 == 1);
            step_req = (i % 3 == 0);
            tick;
            if (halted !== 1'b1 || ctrl !== '0 || instr_done !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL hlt_hold: got %0d bad cycles expected 0", bad); end
        run = 1'b0; step_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL hlt_reset: got %b expected 0", halted); end
        #1 rst_n = 1'b1;
        tick;
        n_checks++; if (halted !== 1'b0 || ctrl !== '0) begin n_errors++; $display("FAIL hlt_after: got %b/%h expected 0/0", halted, ctrl); end
    endtask

    initial begin
        test_reset;
        test_ldi;
        test_sub;
        test_branches;
        test_back_to_back;
        test_step;
        test_reset_mid;
        test_halt;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
